// File: rtl/fifo_host_pkg.sv
// Shared types and constants for the FIFO host read side.
package fifo_host_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int SKID_DEPTH = 2;
   localparam int WC_W       = 16;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order skid buffer; entry 0 is always the head.
import fifo_host_pkg::*;

module fifo_skid_buf #(
   parameter int DATA_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_pop,
   output logic [1:0]            o_occ,
   output logic [DATA_WIDTH-1:0] o_head,
   output logic                  o_ovf
);

   logic [DATA_WIDTH-1:0] r_mem [SKID_DEPTH];
   logic [1:0]            r_occ;
   logic                  r_ovf;
   logic                  w_pop;

   assign w_pop  = i_pop && (r_occ != 2'd0);
   assign o_occ  = r_occ;
   assign o_head = r_mem[0];
   assign o_ovf  = r_ovf;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_occ    <= '0;
         r_ovf    <= 1'b0;
      end else begin
         case ({i_push, w_pop})
            2'b10: begin
               if (r_occ < 2'(SKID_DEPTH)) begin
                  r_mem[r_occ[0]] <= i_data;
                  r_occ           <= r_occ + 2'd1;
               end else begin
                  // a word arriving into a full buffer is dropped
                  r_ovf <= 1'b1;
               end
            end
            2'b01: begin
               r_mem[0] <= r_mem[1];
               r_occ    <= r_occ - 2'd1;
            end
            2'b11: begin
               if (r_occ == 2'd1) begin
                  r_mem[0] <= i_data;
               end else begin
                  r_mem[0] <= r_mem[1];
                  r_mem[1] <= i_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fifo_drain_ctrl.sv
// FIFO read-port to valid/ready stream converter with burst framing.
// state | meaning: IDLE no reads | RUN issuing reads | DRAIN flushing buffered/in-flight words
import fifo_host_pkg::*;

module fifo_drain_ctrl #(
   parameter int DATA_WIDTH = 12,
   parameter int BURST_LEN  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_read_data,
   input  logic                  fifo_valid,
   output logic                  fifo_read_enable,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic                  busy,
   output logic [WC_W-1:0]       word_count
);

   state_t          r_state;
   logic            r_outst;
   logic [7:0]      r_burst;
   logic [WC_W-1:0] r_word_count;
   logic [1:0]      w_occ;
   logic            w_pop;
   logic            w_ovf;
   logic [2:0]      w_inflight;

   fifo_skid_buf #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_skid (
      .clk    (clk),
      .rst    (rst),
      .i_push (fifo_valid),
      .i_data (fifo_read_data),
      .i_pop  (w_pop),
      .o_occ  (w_occ),
      .o_head (out_data),
      .o_ovf  (w_ovf)
   );

   assign out_valid  = (w_occ != 2'd0);
   assign w_pop      = out_valid && out_ready;
   // slots that will be taken once everything already requested lands
   assign w_inflight = {1'b0, w_occ} + {2'b00, r_outst} - {2'b00, w_pop};
   assign fifo_read_enable = !rst && (r_state == RUN) && enable && !fifo_empty
                             && (w_inflight < 3'(SKID_DEPTH));
   assign out_last   = out_valid && (r_burst == 8'(BURST_LEN - 1));
   assign busy       = (r_state != IDLE);
   assign word_count = r_word_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_outst      <= 1'b0;
         r_burst      <= '0;
         r_word_count <= '0;
      end else begin
         r_outst <= fifo_read_enable;
         if (w_pop) begin
            r_word_count <= r_word_count + 1'b1;
            r_burst      <= (r_burst == 8'(BURST_LEN - 1)) ? 8'd0 : r_burst + 8'd1;
         end
         case (r_state)
            IDLE:  if (enable) r_state <= RUN;
            RUN: begin
               if (!enable)
                  r_state <= (w_occ != 2'd0 || r_outst) ? DRAIN : IDLE;
            end
            DRAIN: begin
               if (enable)
                  r_state <= RUN;
               else if (w_occ == 2'd0 && !r_outst)
                  r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !w_ovf);

endmodule

// File: doc/fifo_drain_ctrl.md
Name: fifo_drain_ctrl

Overview:
Read-side controller for the project FIFO host. It turns the FIFO's read port (read_enable / read_data / valid / fifo_empty) into a valid/ready output stream. A 2-entry skid buffer absorbs the FIFO's 1-cycle read latency, and the stream is framed into bursts of BURST_LEN words with a last flag. The block sits between the FIFO host's read port and any downstream consumer.

Parameters:
DATA_WIDTH, 12, width of FIFO words and out_data
BURST_LEN, 8, words per burst; out_last marks the final word of each burst (legal range 1..255)

Ports:
clk  input  1  single clock; all logic on posedge
rst  input  1  synchronous, active-high reset
enable  input  1  level; while high, controller issues FIFO reads
fifo_empty  input  1  FIFO empty flag (registered, may lag occupancy by 1 cycle)
fifo_read_data  input  DATA_WIDTH  FIFO read data, valid with fifo_valid
fifo_valid  input  1  one-cycle pulse, the cycle after an accepted read
fifo_read_enable  output  1  read request to FIFO (combinational)
out_data  output  DATA_WIDTH  stream data (head of skid buffer)
out_valid  output  1  stream valid
out_ready  input  1  downstream ready
out_last  output  1  high with out_valid on the BURST_LEN-th word of a burst
busy  output  1  state != IDLE
word_count  output  16  total words transferred (out_valid && out_ready), wraps at 16'hFFFF -> 0

Behaviour:
- Reset (rst high at posedge): state=IDLE, buffer occupancy=0, outstanding=0, burst counter=0, word_count=0, out_valid=0, out_last=0, out_data=0, busy=0. fifo_read_enable is forced 0 while rst is high.
- Terms: pop = out_valid && out_ready. outst = 1 in the cycle after fifo_read_enable was high, 0 otherwise.
- Read issue rule: fifo_read_enable = (state==RUN) && enable && !fifo_empty && (occ + outst - pop) < 2. This guarantees the buffer never overflows. It sustains 1 word/cycle while out_ready is held high.
- outst clears the cycle after issue whether or not fifo_valid arrives. A stale fifo_empty or a FIFO self-reset can swallow a request; this is legal, and no word, count or burst advance occurs.
- fifo_valid with occ==2 and no pop cannot occur under the issue rule. If it does, the word is dropped and a sticky internal overflow bit is set for assertion checking only.
- Skid buffer: FIFO order preserved. out_data/out_valid come from the head entry. When push and pop happen in the same cycle, occupancy is unchanged.
- Burst counter 0..BURST_LEN-1 advances on pop and wraps to 0 after BURST_LEN-1. out_last = out_valid && (counter == BURST_LEN-1). With BURST_LEN=1, every word is last.
- word_count increments on pop, 16-bit wrap.
- FSM:
  - IDLE -> RUN when enable=1.
  - RUN -> DRAIN when enable=0 and (occ!=0 or outst=1).
  - RUN -> IDLE when enable=0 and occ==0 and outst==0.
  - DRAIN: no new reads. Remaining words are presented. -> IDLE when occ==0 and outst==0.
  - DRAIN -> RUN if enable rises again.
- The burst counter is not cleared on IDLE. Bursts span enable gaps; only rst clears it.
- out_valid stays high and out_data stable until pop (AXI-style; no retraction).

Decomposition:
- Shared package fifo_host_pkg: FSM state enum (IDLE, RUN, DRAIN), skid depth constant SKID_DEPTH=2, word_count width constant WC_W=16.
- Sub-module fifo_skid_buf (2-entry, DATA_WIDTH, push/pop/occ/head outputs) instantiated once. FSM, issue logic and counters stay in fifo_drain_ctrl.

Test Plan:
- Reset, then enable=1, FIFO preloaded with 0x001..0x010, out_ready=1 → words 0x001..0x010 emitted in order at 1/cycle after a 2-cycle fill. out_last on 0x008 and 0x010. word_count=16.
- out_ready=0 for 10 cycles mid-stream → at most 2 reads outstanding/buffered, no drops, out_data held stable. Resume gives in-order output.
- fifo_empty deasserted but FIFO returns no fifo_valid (stale flag) → no output, outst clears next cycle, word_count unchanged.
- enable dropped with occ=2 → state DRAIN, no fifo_read_enable, both words delivered, then IDLE with busy=0.
- rst asserted mid-burst (counter=5, occ=1) → all outputs at reset values next cycle. Next burst out_last on the 8th word.
- word_count preset by 65535 transfers, one more pop → word_count=0.
